// File: rtl/wake_up_ctrl.sv
// wake_up_ctrl: registered source-ready tracking for one CIQ with per-channel latency-aware tag broadcast.
// Optional build macro WAKE_ALLOC_BYPASS_EN: an entry allocated while its tag is on the bus becomes ready at once.
module wake_up_ctrl #(
    parameter int ISSUE_NUM = 4,
    parameter int PRF_WIDTH = 6,
    parameter int CIQ_DEPTH = 16,
    parameter int MAX_LAT   = 4,
    parameter int LAT_WIDTH = 2,
    parameter int IDX_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [ISSUE_NUM-1:0]           grant_vld,
    input  logic [ISSUE_NUM*PRF_WIDTH-1:0] grant_prd,
    input  logic [ISSUE_NUM*LAT_WIDTH-1:0] grant_lat,
    input  logic [ISSUE_NUM-1:0]           grant_rd_en,
    input  logic                           alloc_vld,
    input  logic [IDX_WIDTH-1:0]           alloc_idx,
    input  logic [PRF_WIDTH-1:0]           alloc_prs1,
    input  logic [PRF_WIDTH-1:0]           alloc_prs2,
    input  logic                           alloc_rdy1,
    input  logic                           alloc_rdy2,
    input  logic [CIQ_DEPTH-1:0]           dealloc_mask,
    output logic [CIQ_DEPTH-1:0]           entry_vld,
    output logic [CIQ_DEPTH-1:0]           prs1_rdy,
    output logic [CIQ_DEPTH-1:0]           prs2_rdy,
    output logic [ISSUE_NUM-1:0]           tag_bus_vld,
    output logic [ISSUE_NUM*PRF_WIDTH-1:0] tag_bus,
    output logic                           conflict_err
);

    // grant_vld, alloc_vld and dealloc_mask are single-cycle strobes with no backpressure:
    // every asserted valid is consumed at the next clock edge.
    logic [MAX_LAT-1:0]   slot_vld   [ISSUE_NUM];
    logic [PRF_WIDTH-1:0] slot_tag   [ISSUE_NUM][MAX_LAT];
    logic [MAX_LAT-1:0]   slot_vld_d [ISSUE_NUM];
    logic [PRF_WIDTH-1:0] slot_tag_d [ISSUE_NUM][MAX_LAT];
    logic                 slot_err;

    logic [PRF_WIDTH-1:0] prs1_tag [CIQ_DEPTH];
    logic [PRF_WIDTH-1:0] prs2_tag [CIQ_DEPTH];
    logic [CIQ_DEPTH-1:0] rdy1_q;
    logic [CIQ_DEPTH-1:0] rdy2_q;
    logic [CIQ_DEPTH-1:0] wake1;
    logic [CIQ_DEPTH-1:0] wake2;
    logic                 byp1;
    logic                 byp2;

    // Shift first, then insert; an occupied target slot keeps its older tag.
    always_comb begin
        slot_err = 1'b0;
        for (int i = 0; i < ISSUE_NUM; i++) begin
            for (int k = 0; k < MAX_LAT - 1; k++) begin
                slot_vld_d[i][k] = slot_vld[i][k+1];
                slot_tag_d[i][k] = slot_tag[i][k+1];
            end
            slot_vld_d[i][MAX_LAT-1] = 1'b0;
            slot_tag_d[i][MAX_LAT-1] = '0;
            if (grant_vld[i] && grant_rd_en[i] && (grant_prd[i*PRF_WIDTH +: PRF_WIDTH] != '0)) begin
                if (int'(grant_lat[i*LAT_WIDTH +: LAT_WIDTH]) >= MAX_LAT) begin
                    slot_err = 1'b1;
                end else begin
                    for (int k = 0; k < MAX_LAT; k++) begin
                        if (int'(grant_lat[i*LAT_WIDTH +: LAT_WIDTH]) == k) begin
                            if (slot_vld_d[i][k]) begin
                                slot_err = 1'b1;
                            end else begin
                                slot_vld_d[i][k] = 1'b1;
                                slot_tag_d[i][k] = grant_prd[i*PRF_WIDTH +: PRF_WIDTH];
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ISSUE_NUM; i++) begin
            tag_bus_vld[i]                       = slot_vld[i][0];
            tag_bus[i*PRF_WIDTH +: PRF_WIDTH]    = slot_tag[i][0];
        end
    end

    always_comb begin
        wake1 = '0;
        wake2 = '0;
        for (int e = 0; e < CIQ_DEPTH; e++) begin
            for (int j = 0; j < ISSUE_NUM; j++) begin
                if (tag_bus_vld[j] && (tag_bus[j*PRF_WIDTH +: PRF_WIDTH] == prs1_tag[e])) wake1[e] = 1'b1;
                if (tag_bus_vld[j] && (tag_bus[j*PRF_WIDTH +: PRF_WIDTH] == prs2_tag[e])) wake2[e] = 1'b1;
            end
        end
    end

`ifdef WAKE_ALLOC_BYPASS_EN
    always_comb begin
        byp1 = 1'b0;
        byp2 = 1'b0;
        for (int j = 0; j < ISSUE_NUM; j++) begin
            if (tag_bus_vld[j] && (tag_bus[j*PRF_WIDTH +: PRF_WIDTH] == alloc_prs1)) byp1 = 1'b1;
            if (tag_bus_vld[j] && (tag_bus[j*PRF_WIDTH +: PRF_WIDTH] == alloc_prs2)) byp2 = 1'b1;
        end
    end
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < ISSUE_NUM; i++) begin
                for (int k = 0; k < MAX_LAT; k++) begin
                    slot_vld[i][k] <= 1'b0;
                    slot_tag[i][k] <= '0;
                end
            end
        end else begin
            slot_vld <= slot_vld_d;
            slot_tag <= slot_tag_d;
        end
    end

    // Sticky until reset; a flush deliberately leaves it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_err <= 1'b0;
        end else if (!flush && slot_err) begin
            conflict_err <= 1'b1;
        end
    end

    // Later assignments win: wakeup < dealloc < alloc.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            entry_vld <= '0;
            rdy1_q    <= '0;
            rdy2_q    <= '0;
        end else begin
            for (int e = 0; e < CIQ_DEPTH; e++) begin
                if (dealloc_mask[e]) begin
                    entry_vld[e] <= 1'b0;
                    rdy1_q[e]    <= 1'b0;
                    rdy2_q[e]    <= 1'b0;
                end else if (entry_vld[e]) begin
                    if (wake1[e]) rdy1_q[e] <= 1'b1;
                    if (wake2[e]) rdy2_q[e] <= 1'b1;
                end
            end
            if (alloc_vld) begin
                entry_vld[alloc_idx] <= 1'b1;
                rdy1_q[alloc_idx]    <= alloc_rdy1 | byp1;
                rdy2_q[alloc_idx]    <= alloc_rdy2 | byp2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && alloc_vld) begin
            prs1_tag[alloc_idx] <= alloc_prs1;
            prs2_tag[alloc_idx] <= alloc_prs2;
        end
    end

    assign prs1_rdy = rdy1_q & entry_vld;
    assign prs2_rdy = rdy2_q & entry_vld;

endmodule

// File: tb/tb_wake_up_ctrl.sv
// Bench for wake_up_ctrl: directed vector table plus randomized traffic against an event-time reference model.
`timescale 1ns/1ps
module tb_wake_up_ctrl;

    localparam int ISSUE_NUM = 4;
    localparam int PRF_WIDTH = 6;
    localparam int CIQ_DEPTH = 16;
    localparam int MAX_LAT   = 4;
    localparam int LAT_WIDTH = 2;
    localparam int IDX_WIDTH = 4;
    localparam int EW = 3*CIQ_DEPTH + ISSUE_NUM + ISSUE_NUM*PRF_WIDTH + 1;

`ifdef WAKE_ALLOC_BYPASS_EN
    localparam int BYP_R1 = 'h0040;
`else
    localparam int BYP_R1 = 'h0000;
`endif

    logic                           clk;
    logic                           rst;
    logic                           flush;
    logic [ISSUE_NUM-1:0]           grant_vld;
    logic [ISSUE_NUM*PRF_WIDTH-1:0] grant_prd;
    logic [ISSUE_NUM*LAT_WIDTH-1:0] grant_lat;
    logic [ISSUE_NUM-1:0]           grant_rd_en;
    logic                           alloc_vld;
    logic [IDX_WIDTH-1:0]           alloc_idx;
    logic [PRF_WIDTH-1:0]           alloc_prs1;
    logic [PRF_WIDTH-1:0]           alloc_prs2;
    logic                           alloc_rdy1;
    logic                           alloc_rdy2;
    logic [CIQ_DEPTH-1:0]           dealloc_mask;
    logic [CIQ_DEPTH-1:0]           entry_vld;
    logic [CIQ_DEPTH-1:0]           prs1_rdy;
    logic [CIQ_DEPTH-1:0]           prs2_rdy;
    logic [ISSUE_NUM-1:0]           tag_bus_vld;
    logic [ISSUE_NUM*PRF_WIDTH-1:0] tag_bus;
    logic                           conflict_err;

    wake_up_ctrl #(
        .ISSUE_NUM(ISSUE_NUM), .PRF_WIDTH(PRF_WIDTH), .CIQ_DEPTH(CIQ_DEPTH),
        .MAX_LAT(MAX_LAT), .LAT_WIDTH(LAT_WIDTH), .IDX_WIDTH(IDX_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .grant_vld(grant_vld), .grant_prd(grant_prd), .grant_lat(grant_lat), .grant_rd_en(grant_rd_en),
        .alloc_vld(alloc_vld), .alloc_idx(alloc_idx), .alloc_prs1(alloc_prs1), .alloc_prs2(alloc_prs2),
        .alloc_rdy1(alloc_rdy1), .alloc_rdy2(alloc_rdy2), .dealloc_mask(dealloc_mask),
        .entry_vld(entry_vld), .prs1_rdy(prs1_rdy), .prs2_rdy(prs2_rdy),
        .tag_bus_vld(tag_bus_vld), .tag_bus(tag_bus), .conflict_err(conflict_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    // Broadcasts are kept as scheduled events {channel, due cycle, tag}; a slot collision is
    // simply a second event for the same channel and due cycle.
    typedef struct {
        int                   ch;
        int                   due;
        logic [PRF_WIDTH-1:0] tag;
    } ev_t;

    ev_t                  evq[$];
    int                   n_cyc = 0;
    logic [CIQ_DEPTH-1:0] m_vld = '0;
    logic [CIQ_DEPTH-1:0] m_r1  = '0;
    logic [CIQ_DEPTH-1:0] m_r2  = '0;
    logic [PRF_WIDTH-1:0] m_p1 [CIQ_DEPTH];
    logic [PRF_WIDTH-1:0] m_p2 [CIQ_DEPTH];
    logic                 m_conf = 1'b0;
    logic [EW-1:0]        exp_q[$];

    function automatic int find_ev(input int ch, input int due);
        int r = -1;
        for (int q = 0; q < evq.size(); q++) begin
            if (evq[q].ch == ch && evq[q].due == due) r = q;
        end
        return r;
    endfunction

    function automatic void model_update();
        logic [ISSUE_NUM-1:0] bv;
        logic [PRF_WIDTH-1:0] bt [ISSUE_NUM];
        logic [PRF_WIDTH-1:0] prd;
        int                   lat;
        int                   q;
        ev_t                  ev;
        if (rst) begin
            m_vld = '0; m_r1 = '0; m_r2 = '0; m_conf = 1'b0;
            evq.delete();
        end else if (flush) begin
            m_vld = '0; m_r1 = '0; m_r2 = '0;
            evq.delete();
        end else begin
            for (int j = 0; j < ISSUE_NUM; j++) begin
                q = find_ev(j, n_cyc);
                bv[j] = (q >= 0);
                if (q >= 0) bt[j] = evq[q].tag;
                else        bt[j] = '0;
            end
            for (int i = 0; i < ISSUE_NUM; i++) begin
                prd = grant_prd[i*PRF_WIDTH +: PRF_WIDTH];
                lat = int'(grant_lat[i*LAT_WIDTH +: LAT_WIDTH]);
                if (grant_vld[i] && grant_rd_en[i] && prd != '0) begin
                    if (lat >= MAX_LAT || find_ev(i, n_cyc + 1 + lat) >= 0) begin
                        m_conf = 1'b1;
                    end else begin
                        ev.ch = i; ev.due = n_cyc + 1 + lat; ev.tag = prd;
                        evq.push_back(ev);
                    end
                end
            end
            for (int e = 0; e < CIQ_DEPTH; e++) begin
                if (dealloc_mask[e]) begin
                    m_vld[e] = 1'b0; m_r1[e] = 1'b0; m_r2[e] = 1'b0;
                end else if (m_vld[e]) begin
                    for (int j = 0; j < ISSUE_NUM; j++) begin
                        if (bv[j] && bt[j] == m_p1[e]) m_r1[e] = 1'b1;
                        if (bv[j] && bt[j] == m_p2[e]) m_r2[e] = 1'b1;
                    end
                end
            end
            if (alloc_vld) begin
                m_vld[alloc_idx] = 1'b1;
                m_p1[alloc_idx]  = alloc_prs1;
                m_p2[alloc_idx]  = alloc_prs2;
                m_r1[alloc_idx]  = alloc_rdy1;
                m_r2[alloc_idx]  = alloc_rdy2;
`ifdef WAKE_ALLOC_BYPASS_EN
                for (int j = 0; j < ISSUE_NUM; j++) begin
                    if (bv[j] && bt[j] == alloc_prs1) m_r1[alloc_idx] = 1'b1;
                    if (bv[j] && bt[j] == alloc_prs2) m_r2[alloc_idx] = 1'b1;
                end
`endif
            end
        end
        n_cyc++;
        for (int q2 = evq.size() - 1; q2 >= 0; q2--) begin
            if (evq[q2].due < n_cyc) evq.delete(q2);
        end
    endfunction

    function automatic logic [EW-1:0] exp_now();
        logic [ISSUE_NUM-1:0]           tv = '0;
        logic [ISSUE_NUM*PRF_WIDTH-1:0] tb = '0;
        int q;
        for (int j = 0; j < ISSUE_NUM; j++) begin
            q = find_ev(j, n_cyc);
            if (q >= 0) begin
                tv[j] = 1'b1;
                tb[j*PRF_WIDTH +: PRF_WIDTH] = evq[q].tag;
            end
        end
        return {m_vld, m_r1 & m_vld, m_r2 & m_vld, tv, tb, m_conf};
    endfunction

    function automatic logic [ISSUE_NUM*PRF_WIDTH-1:0] bus_mask(input logic [ISSUE_NUM-1:0] v);
        logic [ISSUE_NUM*PRF_WIDTH-1:0] m = '0;
        for (int j = 0; j < ISSUE_NUM; j++) begin
            if (v[j]) m[j*PRF_WIDTH +: PRF_WIDTH] = '1;
        end
        return m;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic compare_model(input logic [EW-1:0] e);
        logic [CIQ_DEPTH-1:0]           ev, e1, e2;
        logic [ISSUE_NUM-1:0]           etv;
        logic [ISSUE_NUM*PRF_WIDTH-1:0] etb;
        logic                           ec;
        {ev, e1, e2, etv, etb, ec} = e;
        chk($sformatf("model c%0d entry_vld", n_cyc), 64'(entry_vld), 64'(ev));
        chk($sformatf("model c%0d prs1_rdy", n_cyc), 64'(prs1_rdy), 64'(e1));
        chk($sformatf("model c%0d prs2_rdy", n_cyc), 64'(prs2_rdy), 64'(e2));
        chk($sformatf("model c%0d tag_bus_vld", n_cyc), 64'(tag_bus_vld), 64'(etv));
        chk($sformatf("model c%0d tag_bus", n_cyc), 64'(tag_bus & bus_mask(etv)), 64'(etb));
        chk($sformatf("model c%0d conflict_err", n_cyc), 64'(conflict_err), 64'(ec));
    endtask

    // ---------------- driver ----------------
    task automatic step();
        model_update();
        exp_q.push_back(exp_now());
        @(posedge clk);
        #1;
        compare_model(exp_q.pop_front());
    endtask

    typedef struct {
        logic                           rst, flush, av, r1, r2, conf;
        logic [IDX_WIDTH-1:0]           aidx;
        logic [PRF_WIDTH-1:0]           p1, p2;
        logic [ISSUE_NUM-1:0]           gvld, gen, etv;
        logic [ISSUE_NUM*PRF_WIDTH-1:0] gprd, etb;
        logic [ISSUE_NUM*LAT_WIDTH-1:0] glat;
        logic [CIQ_DEPTH-1:0]           dm, evld, er1, er2;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int rs, input int fl, input int av, input int aidx,
                                input int p1, input int p2, input int r1, input int r2,
                                input int gch, input int gprd, input int glat, input int dm,
                                input int evld, input int er1, input int er2,
                                input int bch, input int btag, input int cf);
        vec_t v;
        v.rst = rs[0]; v.flush = fl[0]; v.av = av[0]; v.aidx = aidx[IDX_WIDTH-1:0];
        v.p1 = p1[PRF_WIDTH-1:0]; v.p2 = p2[PRF_WIDTH-1:0]; v.r1 = r1[0]; v.r2 = r2[0];
        v.gvld = '0; v.gen = '0; v.gprd = '0; v.glat = '0;
        if (gch >= 0) begin
            v.gvld[gch] = 1'b1;
            v.gen[gch]  = 1'b1;
            v.gprd[gch*PRF_WIDTH +: PRF_WIDTH] = gprd[PRF_WIDTH-1:0];
            v.glat[gch*LAT_WIDTH +: LAT_WIDTH] = glat[LAT_WIDTH-1:0];
        end
        v.dm = dm[CIQ_DEPTH-1:0];
        v.evld = evld[CIQ_DEPTH-1:0]; v.er1 = er1[CIQ_DEPTH-1:0]; v.er2 = er2[CIQ_DEPTH-1:0];
        v.etv = '0; v.etb = '0;
        if (bch >= 0) begin
            v.etv[bch] = 1'b1;
            v.etb[bch*PRF_WIDTH +: PRF_WIDTH] = btag[PRF_WIDTH-1:0];
        end
        v.conf = cf[0];
        return v;
    endfunction

    task automatic drive_row(input vec_t v);
        rst = v.rst; flush = v.flush;
        alloc_vld = v.av; alloc_idx = v.aidx; alloc_prs1 = v.p1; alloc_prs2 = v.p2;
        alloc_rdy1 = v.r1; alloc_rdy2 = v.r2;
        grant_vld = v.gvld; grant_rd_en = v.gen; grant_prd = v.gprd; grant_lat = v.glat;
        dealloc_mask = v.dm;
    endtask

    task automatic drive_random();
        rst          = ($urandom_range(0, 99) == 0);
        flush        = ($urandom_range(0, 39) == 0);
        alloc_vld    = ($urandom_range(0, 1) == 1);
        alloc_idx    = IDX_WIDTH'($urandom_range(0, CIQ_DEPTH - 1));
        alloc_prs1   = PRF_WIDTH'($urandom_range(0, 7));
        alloc_prs2   = PRF_WIDTH'($urandom_range(0, 7));
        alloc_rdy1   = ($urandom_range(0, 3) == 0);
        alloc_rdy2   = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < ISSUE_NUM; i++) begin
            grant_vld[i]   = ($urandom_range(0, 9) < 4);
            grant_rd_en[i] = ($urandom_range(0, 9) < 8);
            grant_prd[i*PRF_WIDTH +: PRF_WIDTH] = PRF_WIDTH'($urandom_range(0, 7));
            grant_lat[i*LAT_WIDTH +: LAT_WIDTH] = LAT_WIDTH'($urandom_range(0, MAX_LAT - 1));
        end
        dealloc_mask = '0;
        if ($urandom_range(0, 2) == 0) dealloc_mask[$urandom_range(0, CIQ_DEPTH - 1)] = 1'b1;
    endtask

    // ---------------- test ----------------
    initial begin
        rst = 1'b1; flush = 1'b0; alloc_vld = 1'b0; alloc_idx = '0; alloc_prs1 = '0; alloc_prs2 = '0;
        alloc_rdy1 = 1'b0; alloc_rdy2 = 1'b0; grant_vld = '0; grant_prd = '0; grant_lat = '0;
        grant_rd_en = '0; dealloc_mask = '0;
        for (int e = 0; e < CIQ_DEPTH; e++) begin
            m_p1[e] = '0;
            m_p2[e] = '0;
        end
        @(negedge clk);

        //             rs fl av idx p1 p2 r1 r2 gch prd lat dmask   evld    er1     er2   bch btag cf
        tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0, -1,  0, 0, 'h00, 'h0000, 'h0000, 'h0000, -1,  0, 0));
        tbl.push_back(mk(0, 0, 1, 3,  5, 7, 0, 0, -1,  0, 0, 'h00, 'h0008, 'h0000, 'h0000, -1,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  0,  5, 0, 'h00, 'h0008, 'h0000, 'h0000,  0,  5, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  1,  7, 2, 'h00, 'h0008, 'h0008, 'h0000, -1,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, -1,  0, 0, 'h00, 'h0008, 'h0008, 'h0000, -1,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, -1,  0, 0, 'h00, 'h0008, 'h0008, 'h0000,  1,  7, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, -1,  0, 0, 'h00, 'h0008, 'h0008, 'h0008, -1,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  0,  9, 2, 'h00, 'h0008, 'h0008, 'h0008, -1,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 10, 1, 'h00, 'h0008, 'h0008, 'h0008, -1,  0, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, -1,  0, 0, 'h00, 'h0008, 'h0008, 'h0008,  0,  9, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, -1,  0, 0, 'h00, 'h0008, 'h0008, 'h0008, -1,  0, 1));
        tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0, -1,  0, 0, 'h00, 'h0000, 'h0000, 'h0000, -1,  0, 1));
        tbl.push_back(mk(0, 0, 1, 1,  0, 0, 0, 0, -1,  0, 0, 'h00, 'h0002, 'h0000, 'h0000, -1,  0, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  2,  0, 0, 'h00, 'h0002, 'h0000, 'h0000, -1,  0, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, -1,  0, 0, 'h00, 'h0002, 'h0000, 'h0000, -1,  0, 1));
        tbl.push_back(mk(0, 0, 1, 2,  3, 4, 1, 0, -1,  0, 0, 'h06, 'h0004, 'h0004, 'h0000, -1,  0, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  3,  4, 1, 'h00, 'h0004, 'h0004, 'h0000, -1,  0, 1));
        tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0, -1,  0, 0, 'h00, 'h0000, 'h0000, 'h0000, -1,  0, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, -1,  0, 0, 'h00, 'h0000, 'h0000, 'h0000, -1,  0, 1));
        tbl.push_back(mk(0, 0, 1, 5, 20,21, 0, 0,  1, 12, 0, 'h00, 'h0020, 'h0000, 'h0000,  1, 12, 1));
        tbl.push_back(mk(0, 0, 1, 6, 12,13, 0, 0, -1,  0, 0, 'h00, 'h0060, BYP_R1, 'h0000, -1,  0, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  2, 13, 0, 'h00, 'h0060, BYP_R1, 'h0000,  2, 13, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, -1,  0, 0, 'h40, 'h0020, 'h0000, 'h0000, -1,  0, 1));
        tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0, -1,  0, 0, 'h00, 'h0000, 'h0000, 'h0000, -1,  0, 0));

        for (int r = 0; r < tbl.size(); r++) begin
            drive_row(tbl[r]);
            step();
            chk($sformatf("row%0d entry_vld", r), 64'(entry_vld), 64'(tbl[r].evld));
            chk($sformatf("row%0d prs1_rdy", r), 64'(prs1_rdy), 64'(tbl[r].er1));
            chk($sformatf("row%0d prs2_rdy", r), 64'(prs2_rdy), 64'(tbl[r].er2));
            chk($sformatf("row%0d tag_bus_vld", r), 64'(tag_bus_vld), 64'(tbl[r].etv));
            chk($sformatf("row%0d tag_bus", r), 64'(tag_bus & bus_mask(tbl[r].etv)), 64'(tbl[r].etb));
            chk($sformatf("row%0d conflict_err", r), 64'(conflict_err), 64'(tbl[r].conf));
            if (tbl[r].rst) chk($sformatf("row%0d reset tag_bus", r), 64'(tag_bus), 64'(tbl[r].etb));
        end

        for (int c = 0; c < 400; c++) begin
            drive_random();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
